// File: rtl/mem_stage_sb.sv
// MEM stage between EX and WB: aligned loads through a small request FSM, stores posted
// into a store buffer that drains independently of the WB handshake.
module mem_stage_sb #(
   parameter int XLEN     = 32,
   parameter int SB_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rstn_i,
   input  logic              halt_i,
   input  logic              valid_i,
   output logic              ack_o,
   input  logic [31:0]       instr_i,
   input  logic [XLEN-1:0]   result_i,
   input  logic [XLEN-1:0]   rs2_i,
   input  logic [XLEN-1:0]   pc_i,
   output logic              req_o,
   output logic              we_o,
   output logic [XLEN/8-1:0] be_o,
   output logic [XLEN-1:0]   addr_o,
   output logic [XLEN-1:0]   wdata_o,
   input  logic              gnt_i,
   input  logic              rvalid_i,
   input  logic [XLEN-1:0]   rdata_i,
   output logic              valid_o,
   input  logic              ack_i,
   output logic [31:0]       instr_o,
   output logic [XLEN-1:0]   data_o,
   output logic              misalign_o,
   output logic              sb_empty_o,
   output logic [1:0]        ld_state
);
   localparam int NB = XLEN / 8;
   localparam int LN = $clog2(NB);
   localparam int PW = $clog2(SB_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, LD_REQ = 2'd1, LD_WAIT = 2'd2, LD_DONE = 2'd3} ld_state_t;
   ld_state_t state_q;

   // Handshakes: a transfer happens on a clock edge where valid and its ack/gnt are both
   // high; the producer holds its payload stable until that edge.
   logic [6:0]    opcode;
   logic [2:0]    funct3;
   logic [LN-1:0] lane;
   logic          is_load, is_store, is_link, is_nop, misalign;
   logic          slot_free, sb_full, sb_push, sb_pop;
   logic [NB-1:0] st_be;
   logic [XLEN-1:0] st_wdata, ld_data, ld_shift, ld_ext, out_data;

   logic [XLEN-1:0] sb_addr  [SB_DEPTH];
   logic [NB-1:0]   sb_be    [SB_DEPTH];
   logic [XLEN-1:0] sb_wdata [SB_DEPTH];
   logic [PW-1:0]   sb_wptr, sb_rptr;
   logic [CW-1:0]   sb_count;

   assign opcode   = instr_i[6:0];
   assign funct3   = instr_i[14:12];
   assign lane     = result_i[LN-1:0];
   assign is_load  = (opcode == 7'b0000011) && (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
   assign is_store = (opcode == 7'b0100011) && (funct3 inside {3'b000, 3'b001, 3'b010});
   assign is_link  = opcode inside {7'b0010111, 7'b1101111, 7'b1100111};
   assign is_nop   = (opcode == 7'b0000011 || opcode == 7'b0100011) && !is_load && !is_store;
   assign misalign = (is_load || is_store) &&
                     ((funct3[1:0] == 2'b01 && result_i[0]) || (funct3[1:0] == 2'b10 && result_i[1:0] != 2'b00));

   assign slot_free  = !valid_o || ack_i;
   assign sb_full    = (sb_count == CW'(SB_DEPTH));
   assign sb_empty_o = (sb_count == '0);
   assign sb_push    = ack_o && is_store && !misalign;
   assign sb_pop     = !sb_empty_o && gnt_i;
   assign ld_state   = state_q;

   always_comb begin
      ack_o = 1'b0;
      if (valid_i && slot_free && !halt_i) begin
         if (misalign)      ack_o = 1'b1;
         else if (is_store) ack_o = !sb_full;
         else if (is_load)  ack_o = (state_q == LD_DONE);
         else               ack_o = 1'b1;
      end
   end

   always_comb begin
      st_be    = '1;
      st_wdata = rs2_i;
      case (funct3[1:0])
         2'b00: begin st_be = NB'(1) << lane; st_wdata = {NB{rs2_i[7:0]}}; end
         2'b01: begin st_be = NB'(3) << lane; st_wdata = {(NB/2){rs2_i[15:0]}}; end
         default: ;
      endcase
   end

   assign ld_shift = ld_data >> {lane, 3'b000};
   always_comb begin
      case (funct3)
         3'b000:  ld_ext = {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
         3'b001:  ld_ext = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
         3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_shift[7:0]};
         3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
         default: ld_ext = ld_shift;
      endcase
   end

   always_comb begin
      out_data = result_i;
      if (misalign)                out_data = result_i;
      else if (is_load)            out_data = ld_ext;
      else if (is_store || is_nop) out_data = '0;
      else if (is_link)            out_data = pc_i + XLEN'(4);
   end

   // Store drain owns the port whenever the buffer holds anything; loads only start once it is empty.
   always_comb begin
      req_o   = 1'b0;
      we_o    = 1'b0;
      be_o    = '0;
      addr_o  = '0;
      wdata_o = '0;
      if (!sb_empty_o) begin
         req_o   = 1'b1;
         we_o    = 1'b1;
         be_o    = sb_be[sb_rptr];
         addr_o  = sb_addr[sb_rptr];
         wdata_o = sb_wdata[sb_rptr];
      end else if (state_q == LD_REQ) begin
         req_o  = 1'b1;
         be_o   = '1;
         addr_o = {result_i[XLEN-1:2], 2'b00};
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn_i) begin
         sb_wptr  <= '0;
         sb_rptr  <= '0;
         sb_count <= '0;
         for (int i = 0; i < SB_DEPTH; i++) begin
            sb_addr[i]  <= '0;
            sb_be[i]    <= '0;
            sb_wdata[i] <= '0;
         end
      end else begin
         if (sb_push) begin
            sb_addr[sb_wptr]  <= {result_i[XLEN-1:2], 2'b00};
            sb_be[sb_wptr]    <= st_be;
            sb_wdata[sb_wptr] <= st_wdata;
            sb_wptr           <= sb_wptr + PW'(1);
         end
         if (sb_pop) sb_rptr <= sb_rptr + PW'(1);
         case ({sb_push, sb_pop})
            2'b10:   sb_count <= sb_count + CW'(1);
            2'b01:   sb_count <= sb_count - CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn_i) begin
         state_q    <= IDLE;
         ld_data    <= '0;
         valid_o    <= 1'b0;
         instr_o    <= '0;
         data_o     <= '0;
         misalign_o <= 1'b0;
      end else begin
         case (state_q)
            IDLE:    if (valid_i && is_load && !misalign && sb_empty_o) state_q <= LD_REQ;
            LD_REQ:  if (gnt_i && sb_empty_o) state_q <= LD_WAIT;
            LD_WAIT: if (rvalid_i) begin
                        ld_data <= rdata_i;
                        state_q <= LD_DONE;
                     end
            LD_DONE: if (ack_o) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
         if (ack_o) begin
            valid_o    <= 1'b1;
            instr_o    <= instr_i;
            data_o     <= out_data;
            misalign_o <= misalign;
         end else if (ack_i) begin
            valid_o <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_mem_stage_sb.sv
// Directed bench for mem_stage_sb: WB outputs and drained stores are checked against
// expected queues filled when stimulus is issued.
module tb_mem_stage_sb;
   localparam int XLEN = 32;
   localparam int SB_DEPTH = 4;
   localparam logic [6:0] OP_LOAD = 7'h03, OP_STORE = 7'h23, OP_ALU = 7'h33,
                          OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67;

   logic clk, rstn_i, halt_i, valid_i, ack_o;
   logic [31:0] instr_i, result_i, rs2_i, pc_i;
   logic req_o, we_o, gnt_i, rvalid_i, valid_o, ack_i, misalign_o, sb_empty_o;
   logic [3:0] be_o;
   logic [31:0] addr_o, wdata_o, rdata_i, instr_o, data_o;
   logic [1:0] ld_state;

   int n_cmp = 0;
   int n_bad = 0;
   logic [64:0] exp_q[$];
   logic [67:0] exp_st_q[$];
   bit gnt_en = 1'b1;
   int rv_delay = 1;
   int rv_cnt = 0;
   logic [31:0] rd_word = '0;
   logic [31:0] ld_exp_addr = '0;

   mem_stage_sb #(.XLEN(XLEN), .SB_DEPTH(SB_DEPTH)) dut (
      .clk(clk), .rstn_i(rstn_i), .halt_i(halt_i), .valid_i(valid_i), .ack_o(ack_o),
      .instr_i(instr_i), .result_i(result_i), .rs2_i(rs2_i), .pc_i(pc_i),
      .req_o(req_o), .we_o(we_o), .be_o(be_o), .addr_o(addr_o), .wdata_o(wdata_o),
      .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
      .valid_o(valid_o), .ack_i(ack_i), .instr_o(instr_o), .data_o(data_o),
      .misalign_o(misalign_o), .sb_empty_o(sb_empty_o), .ld_state(ld_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
      return {17'h0, f3, rd, op};
   endfunction

   // driver tasks; callers start at a falling edge
   task automatic present(input logic [31:0] ins, input logic [31:0] res, input logic [31:0] r2,
                          input logic [31:0] pc, input logic [31:0] exp_d, input logic exp_m);
      instr_i = ins; result_i = res; rs2_i = r2; pc_i = pc; valid_i = 1'b1;
      exp_q.push_back({exp_m, exp_d, ins});
   endtask

   task automatic wait_ack(input string name, input int budget);
      int n;
      n = 0;
      #1;
      while (!ack_o && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      n_cmp++;
      if (!ack_o) begin
         n_bad++;
         $display("FAIL %s_ack: ack_o=%0b after %0d cycles, expected 1", name, ack_o, budget);
         exp_q.delete(exp_q.size() - 1);
      end
      @(negedge clk);
      valid_i = 1'b0;
   endtask

   task automatic send(input string name, input logic [31:0] ins, input logic [31:0] res,
                       input logic [31:0] r2, input logic [31:0] pc, input logic [31:0] exp_d,
                       input logic exp_m, input int budget);
      present(ins, res, r2, pc, exp_d, exp_m);
      wait_ack(name, budget);
   endtask

   // scoreboard: WB output monitor
   initial begin
      logic [64:0] e;
      forever begin
         @(negedge clk); #2;
         if (rstn_i && valid_o && ack_i) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_output: instr_o=%0h data_o=%0h, expected none", instr_o, data_o);
            end else begin
               e = exp_q.pop_front();
               check("out_instr", instr_o, e[31:0]);
               check("out_data", data_o, e[63:32]);
               check("out_misalign", misalign_o, e[64]);
            end
         end
      end
   end

   // memory responder plus drained-store checker
   initial begin
      logic [67:0] s;
      gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0;
      forever begin
         @(negedge clk); #2;
         rvalid_i = 1'b0;
         if (rv_cnt > 0) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
               rvalid_i = 1'b1;
               rdata_i = rd_word;
            end
         end
         gnt_i = gnt_en && req_o;
         if (gnt_i) begin
            if (we_o) begin
               if (exp_st_q.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL unexpected_store: addr_o=%0h wdata_o=%0h, expected none", addr_o, wdata_o);
               end else begin
                  s = exp_st_q.pop_front();
                  check("st_addr", addr_o, s[67:36]);
                  check("st_be", be_o, s[35:32]);
                  check("st_wdata", wdata_o, s[31:0]);
               end
            end else begin
               check("rd_addr", addr_o, ld_exp_addr);
               check("rd_be", be_o, 4'hF);
               rv_cnt = rv_delay;
            end
         end
      end
   end

   initial begin
      int n;
      rstn_i = 1'b0; halt_i = 1'b0; valid_i = 1'b0; ack_i = 1'b1;
      instr_i = '0; result_i = '0; rs2_i = '0; pc_i = '0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_valid_o", valid_o, 0);
      check("rst_instr_o", instr_o, 0);
      check("rst_data_o", data_o, 0);
      check("rst_misalign_o", misalign_o, 0);
      check("rst_req_o", req_o, 0);
      check("rst_sb_empty_o", sb_empty_o, 1);
      check("rst_ack_o", ack_o, 0);
      check("rst_ld_state", ld_state, 0);
      rstn_i = 1'b1;
      @(negedge clk);

      // aligned loads and lane extraction
      ld_exp_addr = 32'h100;
      rd_word = 32'h8000_00F0;
      send("lw", mk(OP_LOAD, 3'b010, 5'd1), 32'h100, 0, 0, 32'h8000_00F0, 1'b0, 10);
      rd_word = 32'h8012_3456;
      send("lb", mk(OP_LOAD, 3'b000, 5'd2), 32'h103, 0, 0, 32'hFFFF_FF80, 1'b0, 10);
      send("lbu", mk(OP_LOAD, 3'b100, 5'd3), 32'h103, 0, 0, 32'h0000_0080, 1'b0, 10);
      send("lh", mk(OP_LOAD, 3'b001, 5'd4), 32'h102, 0, 0, 32'hFFFF_8012, 1'b0, 10);
      send("lhu", mk(OP_LOAD, 3'b101, 5'd5), 32'h102, 0, 0, 32'h0000_8012, 1'b0, 10);
      send("lb1", mk(OP_LOAD, 3'b000, 5'd6), 32'h101, 0, 0, 32'h0000_0034, 1'b0, 10);

      // stores: single-cycle accept, lane-shifted buffer entries
      exp_st_q.push_back({32'h200, 4'b1100, 32'h1234_1234});
      send("sh", mk(OP_STORE, 3'b001, 5'd0), 32'h202, 32'h0000_1234, 0, 0, 1'b0, 0);
      exp_st_q.push_back({32'h300, 4'b0010, 32'hABAB_ABAB});
      send("sb", mk(OP_STORE, 3'b000, 5'd0), 32'h301, 32'hFFFF_FFAB, 0, 0, 1'b0, 0);
      exp_st_q.push_back({32'h304, 4'b1111, 32'hCAFE_F00D});
      send("sw", mk(OP_STORE, 3'b010, 5'd0), 32'h304, 32'hCAFE_F00D, 0, 0, 1'b0, 0);

      // pass-through opcodes; any memory read from here on is unexpected
      ld_exp_addr = 32'hFFFF_FFFF;
      send("alu", mk(OP_ALU, 3'b000, 5'd7), 32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF, 1'b0, 0);
      send("auipc", mk(OP_AUIPC, 3'b000, 5'd8), 32'h55, 0, 32'h1000, 32'h1004, 1'b0, 0);
      send("jal_wrap", mk(OP_JAL, 3'b000, 5'd9), 32'h55, 0, 32'hFFFF_FFFC, 32'h0, 1'b0, 0);
      send("jalr", mk(OP_JALR, 3'b000, 5'd10), 32'h55, 0, 32'h2000, 32'h2004, 1'b0, 0);
      send("load_f3_011", mk(OP_LOAD, 3'b011, 5'd11), 32'h100, 0, 0, 32'h0, 1'b0, 0);
      send("store_f3_100", mk(OP_STORE, 3'b100, 5'd0), 32'h100, 32'h99, 0, 32'h0, 1'b0, 0);

      // misaligned: no memory access, address returned as data
      send("mis_lw", mk(OP_LOAD, 3'b010, 5'd12), 32'h102, 0, 0, 32'h102, 1'b1, 0);
      send("mis_sh", mk(OP_STORE, 3'b001, 5'd0), 32'h203, 32'h1, 0, 32'h203, 1'b1, 0);
      send("mis_lh", mk(OP_LOAD, 3'b001, 5'd13), 32'h101, 0, 0, 32'h101, 1'b1, 0);
      send("mis_sw", mk(OP_STORE, 3'b010, 5'd0), 32'h206, 32'h1, 0, 32'h206, 1'b1, 0);
      repeat (2) @(negedge clk);
      check("sb_empty_after_stores", sb_empty_o, 1);

      // fill the buffer with grants withheld, then one grant frees one slot
      gnt_en = 1'b0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         exp_st_q.push_back({32'h400 + 32'(4 * i), 4'hF, 32'(32'h1111_1111 * (i + 1))});
         send("sw_fill", mk(OP_STORE, 3'b010, 5'd0), 32'h400 + 32'(4 * i), 32'(32'h1111_1111 * (i + 1)), 0, 0, 1'b0, 0);
      end
      exp_st_q.push_back({32'h410, 4'hF, 32'h5555_5555});
      present(mk(OP_STORE, 3'b010, 5'd0), 32'h410, 32'h5555_5555, 0, 0, 1'b0);
      repeat (3) begin
         #1 check("sb_full_stall", ack_o, 0);
         @(negedge clk);
      end
      gnt_en = 1'b1;
      #3 check("sb_same_cycle_drain", ack_o, 0);
      @(negedge clk);
      gnt_en = 1'b0;
      wait_ack("sw_after_gnt", 0);

      // load behind buffered stores waits for an empty buffer
      ld_exp_addr = 32'h480;
      rd_word = 32'h0BAD_F00D;
      present(mk(OP_LOAD, 3'b010, 5'd14), 32'h480, 0, 0, 32'h0BAD_F00D, 1'b0);
      repeat (3) begin
         #1 check("ld_wait_sb_state", ld_state, 0);
         check("ld_wait_sb_empty", sb_empty_o, 0);
         @(negedge clk);
      end
      gnt_en = 1'b1;
      wait_ack("lw_after_sw", 30);

      // reset drops buffered stores
      gnt_en = 1'b0;
      send("sw_drop0", mk(OP_STORE, 3'b010, 5'd0), 32'h600, 32'h6, 0, 0, 1'b0, 0);
      send("sw_drop1", mk(OP_STORE, 3'b010, 5'd0), 32'h604, 32'h7, 0, 0, 1'b0, 0);
      repeat (2) @(negedge clk);
      #1 check("sb_holds_before_rst", sb_empty_o, 0);
      rstn_i = 1'b0;
      @(negedge clk);
      rstn_i = 1'b1;
      #1 check("sb_empty_after_rst", sb_empty_o, 1);
      check("req_after_rst", req_o, 0);
      gnt_en = 1'b1;
      @(negedge clk);

      // reset in LD_WAIT; the late rvalid must be ignored
      rv_delay = 3;
      ld_exp_addr = 32'h500;
      rd_word = 32'h1357_9BDF;
      present(mk(OP_LOAD, 3'b010, 5'd15), 32'h500, 0, 0, 32'h1357_9BDF, 1'b0);
      n = 0;
      #1;
      while (ld_state != 2'd2 && n < 20) begin
         @(negedge clk); #1;
         n++;
      end
      check("reach_ld_wait", ld_state, 2);
      rstn_i = 1'b0;
      valid_i = 1'b0;
      exp_q.delete(exp_q.size() - 1);
      @(negedge clk);
      rstn_i = 1'b1;
      repeat (5) begin
         #1 check("rst_ld_valid_o", valid_o, 0);
         @(negedge clk);
      end
      check("rst_ld_state_idle", ld_state, 0);
      check("rst_ld_sb_empty", sb_empty_o, 1);
      rv_delay = 1;

      // halt blocks acceptance while the buffer keeps draining
      gnt_en = 1'b0;
      exp_st_q.push_back({32'h700, 4'hF, 32'h7777_7777});
      send("sw_h0", mk(OP_STORE, 3'b010, 5'd0), 32'h700, 32'h7777_7777, 0, 0, 1'b0, 0);
      exp_st_q.push_back({32'h704, 4'hF, 32'h8888_8888});
      send("sw_h1", mk(OP_STORE, 3'b010, 5'd0), 32'h704, 32'h8888_8888, 0, 0, 1'b0, 0);
      @(negedge clk);
      halt_i = 1'b1;
      gnt_en = 1'b1;
      present(mk(OP_ALU, 3'b000, 5'd16), 32'h1234_5678, 0, 0, 32'h1234_5678, 1'b0);
      repeat (5) begin
         #1 check("halt_ack", ack_o, 0);
         @(negedge clk);
      end
      #1 check("halt_drain", sb_empty_o, 1);
      halt_i = 1'b0;
      wait_ack("after_halt", 0);

      n = 0;
      while ((exp_q.size() != 0 || exp_st_q.size() != 0) && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0 || exp_st_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d outputs and %0d stores outstanding, expected 0", exp_q.size(), exp_st_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
